// File: rtl/rx_sym_lock.sv
// Receive-side symbol lock: acquires on repeated COM symbols, supervises COM
// spacing while locked, and forwards non-COM/non-SKP bytes downstream.
module rx_sym_lock #(
    parameter int N_LOCK   = 4,
    parameter int N_UNLOCK = 3,
    parameter int MAX_GAP  = 16,
    parameter int GAP_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic [7:0] rx_DataS,
    input  logic       rx_Valid,
    output logic       sync,
    output logic [7:0] data_out,
    output logic       ctrl_out,
    output logic       data_valid,
    output logic [7:0] err_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        LOSS   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        CHECK  = 2'd3
    } state_e;

    localparam int CW = $clog2(N_LOCK + 1);
    localparam int BW = $clog2(N_UNLOCK + 1);
    localparam logic [CW-1:0]    COM_LAST = CW'(N_LOCK - 1);
    localparam logic [BW-1:0]    BAD_LAST = BW'(N_UNLOCK - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      com_cnt_q, com_cnt_d;
    logic [BW-1:0]      bad_cnt_q, bad_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               sync_q, sync_d;
    logic [7:0]         data_q, data_d;
    logic               ctrl_q, ctrl_d;
    logic               dvld_q, dvld_d;

    logic is_com, is_skp, viol;

    assign is_com = rx_Valid && (rx_DataS == 8'hBC);
    assign is_skp = rx_Valid && (rx_DataS == 8'h1C);
    // A COM in the same cycle always clears the gap, so it can never violate.
    assign viol   = !is_com && (gap_cnt_q == GAP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LOSS;
            com_cnt_q <= '0;
            bad_cnt_q <= '0;
            gap_cnt_q <= '0;
            err_cnt_q <= '0;
            sync_q    <= 1'b0;
            data_q    <= '0;
            ctrl_q    <= 1'b0;
            dvld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            bad_cnt_q <= bad_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            err_cnt_q <= err_cnt_d;
            sync_q    <= sync_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            dvld_q    <= dvld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        bad_cnt_d = bad_cnt_q;
        gap_cnt_d = gap_cnt_q;
        err_cnt_d = err_cnt_q;
        if (enb) begin
            if (is_com || viol) gap_cnt_d = '0;
            else                gap_cnt_d = gap_cnt_q + GAP_W'(1);
            case (state_q)
                LOSS: begin
                    if (is_com) begin
                        state_d   = ACQ;
                        com_cnt_d = CW'(1);
                    end
                end
                ACQ: begin
                    if (is_com) begin
                        if (com_cnt_q == COM_LAST) begin
                            state_d   = LOCKED;
                            com_cnt_d = '0;
                        end else begin
                            com_cnt_d = com_cnt_q + CW'(1);
                        end
                    end else if (viol) begin
                        state_d   = LOSS;
                        com_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (viol) begin
                        state_d   = CHECK;
                        bad_cnt_d = BW'(1);
                        err_cnt_d = sat_inc8(err_cnt_q);
                    end
                end
                CHECK: begin
                    if (is_com) begin
                        state_d   = LOCKED;
                        bad_cnt_d = '0;
                    end else if (viol) begin
                        err_cnt_d = sat_inc8(err_cnt_q);
                        if (bad_cnt_q == BAD_LAST) begin
                            state_d   = LOSS;
                            bad_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + BW'(1);
                        end
                    end
                end
                default: state_d = LOSS;
            endcase
        end
    end

    // Forwarding decision uses the state before this symbol's update.
    always_comb begin
        dvld_d = enb && (state_q == LOCKED || state_q == CHECK) && !is_com && !is_skp;
        data_d = dvld_d ? rx_DataS : data_q;
        ctrl_d = dvld_d ? rx_Valid : ctrl_q;
        sync_d = (state_d == LOCKED) || (state_d == CHECK);
    end

    assign sync       = sync_q;
    assign data_out   = data_q;
    assign ctrl_out   = ctrl_q;
    assign data_valid = dvld_q;
    assign err_cnt    = err_cnt_q;
    assign state      = state_q;

endmodule

// File: doc/rx_sym_lock.md
Name: rx_sym_lock

Overview:
- Receive-side symbol-lock stage, directly downstream of the K28.5/control-symbol detector.
- Consumes the detector's registered byte stream (rx_DataS) and control flag (rx_Valid).
- Declares link lock after N_LOCK COM symbols, supervises COM spacing while locked, and drops lock after repeated spacing violations.
- While locked, forwards data and control bytes downstream, stripping COM and SKP.

Parameters:
- N_LOCK, 4: number of COM symbols needed to reach LOCKED from LOSS; minimum 2.
- N_UNLOCK, 3: number of COM-gap violations, without an intervening COM, that drop lock.
- MAX_GAP, 16: consecutive non-COM symbols that constitute one gap violation.
- GAP_W, 8: width of the gap counter; must satisfy 2^GAP_W > MAX_GAP.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous active-low reset; 0 = reset.
- enb  in  1  symbol strobe; one symbol is consumed per clk while enb=1.
- rx_DataS  in  8  received byte from the detector.
- rx_Valid  in  1  1 = rx_DataS is a control (K) symbol.
- sync  out  1  1 = link locked (state LOCKED or CHECK).
- data_out  out  8  forwarded byte.
- ctrl_out  out  1  control flag of data_out.
- data_valid  out  1  data_out/ctrl_out are valid this cycle.
- err_cnt  out  8  saturating count of gap violations seen while sync=1.
- state  out  2  FSM state (debug).

Behaviour:
- Reset (rst=0, async): state=LOSS(2'd0). com_cnt, gap_cnt, bad_cnt = 0. sync, data_out, ctrl_out, data_valid, err_cnt = 0.
- Symbol decode:
  - COM = rx_Valid && rx_DataS==8'hBC.
  - SKP = rx_Valid && rx_DataS==8'h1C.
- enb=0: state and all counters hold; data_valid<=0; data_out and ctrl_out hold.
- Gap counter (enb=1, every state):
  - COM -> gap_cnt<=0.
  - Non-COM with gap_cnt==MAX_GAP-1 -> violation event, gap_cnt<=0.
  - Other non-COM -> gap_cnt+1.
  - Result: the MAX_GAP-th consecutive non-COM symbol raises a violation. COM in the same cycle always wins; no violation.
- FSM transitions (enb=1; all updates registered):
  - LOSS(0): COM -> ACQ, com_cnt<=1. Violations are ignored.
  - ACQ(1):
    - COM with com_cnt==N_LOCK-1 -> LOCKED, com_cnt<=0.
    - Other COM -> com_cnt+1.
    - Violation -> LOSS, com_cnt<=0.
  - LOCKED(2):
    - COM -> stay.
    - Violation -> CHECK, bad_cnt<=1, err_cnt+1.
  - CHECK(3):
    - COM -> LOCKED, bad_cnt<=0.
    - Violation with bad_cnt==N_UNLOCK-1 -> LOSS, bad_cnt<=0, err_cnt+1.
    - Other violation -> bad_cnt+1, err_cnt+1.
- sync is registered: sync <= (next state is LOCKED or CHECK). sync therefore rises in the cycle after the clock edge that accepts the N_LOCK-th COM.
- err_cnt saturates at 8'hFF and is cleared only by reset.
- Datapath (enb=1), 1-cycle latency:
  - Forwarding is evaluated against the pre-update state.
  - If the pre-update state is LOCKED or CHECK, and the byte is neither COM nor SKP: data_out<=rx_DataS, ctrl_out<=rx_Valid, data_valid<=1.
  - Otherwise data_valid<=0.
  - Consequences: the byte accepted on the LOCKED->LOSS edge is still forwarded. The byte accepted on the ACQ->LOCKED edge is a COM and is not forwarded.
- Non-COM control symbols (STP, SDP, END, EDB, FTS, IDLE) are forwarded with ctrl_out=1. They are not interpreted.
- Reset mid-operation: all state and outputs clear immediately and asynchronously; a full re-acquisition is required.

Test Plan:
- Reset: drive stimulus, assert rst=0 mid-stream -> next sample shows state=0, sync=0, data_valid=0, err_cnt=0, with no waiting for a clk edge.
- Acquisition: four times [COM, 8'h11, 8'h22, 8'h33] with rx_Valid=1 only on COM -> sync=1 the cycle after the 4th COM. The following 8'h11/22/33 appear on data_out one cycle after input with data_valid=1, ctrl_out=0. No data_valid during ACQ.
- Stripping: while locked, send COM, SKP, SKP, SKP, 8'hA5, STP(8'hFB, rx_Valid=1) -> data_valid=0 for COM and SKP. Then data_out=8'hA5, ctrl_out=0, followed by data_out=8'hFB, ctrl_out=1.
- Loss of lock: locked, then 16 non-COM symbols -> state=3, err_cnt=1, sync=1. After 32 more -> err_cnt=3, state=0, sync=0. The 48th byte is still forwarded; later bytes give data_valid=0.
- Recovery and boundary:
  - In CHECK, a COM arrives on the 15th symbol -> LOCKED, no violation, err_cnt unchanged.
  - A later single violation -> CHECK only, no unlock.
- Gating: in ACQ with com_cnt=2, hold enb=0 for 40 cycles with arbitrary input -> state, com_cnt and gap_cnt unchanged, data_valid=0. Two further COMs with enb=1 -> sync=1.
